sim_run_ctrl: RTL
=================

Name: sim_run_ctrl

Overview:
Synthesizable run-sequencing controller for the simulation top around SimTop. It generates the DUT reset window, performs a one-shot init handshake with the host-side DPI agent, then issues one step request per run cycle until the agent reports termination or the max-cycle limit is hit. It also produces the free-running DUT cycle count and the log-window enable that feeds the log-control inputs.

Parameters:
RESET_CYCLES, 50, number of clock cycles dut_reset is held after controller reset (minimum 1)
CNT_W, 64, width of cycle counter and cycle configuration inputs

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous active-high reset
cfg_max_cycles  in  CNT_W  cycle limit; 0 = unlimited; sampled on HOLD->INIT
cfg_log_begin  in  CNT_W  first logged cycle (inclusive)
cfg_log_end  in  CNT_W  log stop cycle (exclusive)
dut_reset  out  1  reset to DUT
init_req  out  1  init request to host agent
init_ack  in  1  host init complete
step_req  out  1  step request to host agent
step_ack  in  1  host step complete
step_code  in  8  step result, valid with step_ack; 0 = continue, non-zero = terminate
cycle_cnt  out  CNT_W  DUT cycles since dut_reset release
log_en  out  1  inside log window
finish  out  1  run ended, sticky
finish_cause  out  2  0 none, 1 agent terminate, 2 max cycles
exit_code  out  8  captured step_code on cause 1, else 0

Behaviour:
- Reset (async, active-high) values: state=HOLD, dut_reset=1, init_req=0, step_req=0, cycle_cnt=0, log_en=0, finish=0, finish_cause=0, exit_code=0, rst_cnt=0, max_q=0.
- State HOLD: dut_reset=1; rst_cnt increments each cycle. When rst_cnt==RESET_CYCLES-1 -> INIT, latch max_q<=cfg_max_cycles. dut_reset is 0 from the first INIT cycle, so exactly RESET_CYCLES cycles of dut_reset after reset release.
- State INIT: init_req=1 (registered, asserted from first INIT cycle). init_ack sampled high -> RUN; init_req deasserts the same edge. init_ack outside INIT is ignored.
- State RUN: step_req=1 every cycle. step_req is level; step_ack completes one step per cycle it is high. step_ack with step_code!=0 -> DONE, finish_cause=1, exit_code=step_code. step_ack low -> stall, no state change.
- Max limit: in RUN, if max_q!=0 and cycle_cnt+1>=max_q at an edge -> DONE, finish_cause=2. First DONE cycle shows cycle_cnt==max_q.
- Simultaneous terminate step_ack and max limit on the same edge: cause 1 wins; exit_code captured.
- State DONE: sticky until reset; finish=1; step_req=0; init_req=0; dut_reset=0; cycle_cnt frozen; further acks ignored.
- cycle_cnt: increments on every edge while state is INIT or RUN and the next state is not DONE, except on the terminating edge where it still increments (counts the final cycle). Saturates at all-ones, no wrap.
- log_en: registered; next value = (next cycle_cnt >= cfg_log_begin) && (next cycle_cnt < cfg_log_end); cfg_log_end <= cfg_log_begin gives 0. Forced 0 in HOLD.
- Reset mid-run: returns to HOLD immediately (async); a full RESET_CYCLES sequence and init re-run.
- finish_cause and exit_code change only on the DONE-entry edge.

Decomposition:
- sim_ctrl_pkg: state enum {HOLD, INIT, RUN, DONE}; cause enum {CAUSE_NONE=0, CAUSE_AGENT=1, CAUSE_MAXCYC=2}; STEP_CONTINUE=8'd0 constant.
- No sub-module needed. The saturating counter and window compare stay inline.

Test Plan:
- RESET_CYCLES=4, init_ack the second INIT cycle -> dut_reset high exactly 4 cycles after reset release; init_req high 2 cycles; step_req rises the next cycle.
- Run with step_ack=1, code 0, cfg_max_cycles=10 -> finish=1, finish_cause=2, cycle_cnt=10, step_req=0 from that cycle, exit_code=0.
- step_ack with step_code=8'h03 at cycle_cnt=5 (max 0) -> finish_cause=1, exit_code=3, cycle_cnt frozen at 6.
- max_q=7 and step_code=8'h01 acked on the same edge -> finish_cause=1, exit_code=1.
- cfg_log_begin=3, cfg_log_end=6 -> log_en high exactly while cycle_cnt in {3,4,5}. begin=end=0 -> log_en never high.
- Assert reset in RUN at cycle_cnt=20 -> all outputs at reset values; a full 4-cycle hold and init repeat. Preloaded cycle_cnt near all-ones saturates without wrap.

Source files
------------

// File: rtl/sim_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sim_ctrl_pkg
// Description : Shared types and constants for the simulation run-sequencing
//               controller (state encoding, finish-cause encoding, step code).
// Revision    : 1.0 - initial release
// ============================================================================
package sim_ctrl_pkg;

    // Controller phases: DUT reset hold, host init handshake, stepping, ended.
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Why the run ended; the encoding is visible on finish_cause.
    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_AGENT  = 2'd1,
        CAUSE_MAXCYC = 2'd2
    } cause_e;

    // Step result meaning "keep running"; anything else terminates the run.
    localparam logic [7:0] STEP_CONTINUE = 8'd0;

endpackage : sim_ctrl_pkg
`default_nettype wire

// File: rtl/sim_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sim_run_ctrl
// Description : Run sequencer for the simulation top. Holds the DUT in reset
//               for RESET_CYCLES clocks, performs a one-shot init handshake
//               with the host agent, then requests one step per cycle until
//               the agent terminates or the cycle limit is reached. Also
//               provides the DUT cycle count and the log-window enable.
// Ports       :
//   clock, reset                  - clock, async active-high reset
//   cfg_max_cycles                - cycle limit (0 = unlimited), latched on
//                                   leaving HOLD
//   cfg_log_begin / cfg_log_end   - log window [begin, end) in DUT cycles
//   dut_reset                     - reset to the DUT (high during HOLD)
//   init_req / init_ack           - host init handshake
//   step_req / step_ack/step_code - per-cycle step handshake and result
//   cycle_cnt                     - saturating DUT cycle count
//   log_en                        - cycle_cnt inside the log window
//   finish/finish_cause/exit_code - sticky end-of-run status
// Revision    : 1.0 - initial release
// ============================================================================
module sim_run_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = 50,
    parameter int CNT_W        = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] cfg_max_cycles,
    input  logic [CNT_W-1:0] cfg_log_begin,
    input  logic [CNT_W-1:0] cfg_log_end,
    output logic             dut_reset,
    output logic             init_req,
    input  logic             init_ack,
    output logic             step_req,
    input  logic             step_ack,
    input  logic [7:0]       step_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             log_en,
    output logic             finish,
    output logic [1:0]       finish_cause,
    output logic [7:0]       exit_code
);

    localparam int              RC_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    state_e            state, state_nxt;
    cause_e            cause_q, cause_nxt;
    logic [RC_W-1:0]   rst_cnt, rst_cnt_nxt;
    logic [CNT_W-1:0]  max_q, max_nxt;
    logic [CNT_W-1:0]  cnt_nxt, cnt_inc;
    logic [CNT_W:0]    cnt_plus1;
    logic [7:0]        exit_nxt;
    logic              log_nxt;
    logic              reach_max;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= HOLD;
            cause_q   <= CAUSE_NONE;
            rst_cnt   <= '0;
            max_q     <= '0;
            cycle_cnt <= '0;
            exit_code <= 8'd0;
            log_en    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cause_q   <= cause_nxt;
            rst_cnt   <= rst_cnt_nxt;
            max_q     <= max_nxt;
            cycle_cnt <= cnt_nxt;
            exit_code <= exit_nxt;
            log_en    <= log_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        cause_nxt   = cause_q;
        rst_cnt_nxt = rst_cnt;
        max_nxt     = max_q;
        cnt_nxt     = cycle_cnt;
        exit_nxt    = exit_code;

        // One extra bit so the limit compare stays correct at all-ones.
        cnt_plus1 = {1'b0, cycle_cnt} + {{CNT_W{1'b0}}, 1'b1};
        cnt_inc   = (cycle_cnt == CNT_SAT) ? cycle_cnt : cnt_plus1[CNT_W-1:0];
        reach_max = (max_q != '0) && (cnt_plus1 >= {1'b0, max_q});

        case (state)
            HOLD: begin
                rst_cnt_nxt = rst_cnt + RC_W'(1);
                if (rst_cnt == RC_LAST) begin
                    state_nxt   = INIT;
                    rst_cnt_nxt = '0;
                    max_nxt     = cfg_max_cycles;
                end
            end
            INIT: begin
                cnt_nxt = cnt_inc;
                if (init_ack) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // The terminating edge still counts the final cycle.
                cnt_nxt = cnt_inc;
                // Agent termination takes priority over the cycle limit.
                if (step_ack && (step_code != STEP_CONTINUE)) begin
                    state_nxt = DONE;
                    cause_nxt = CAUSE_AGENT;
                    exit_nxt  = step_code;
                end else if (reach_max) begin
                    state_nxt = DONE;
                    cause_nxt = CAUSE_MAXCYC;
                    exit_nxt  = 8'd0;
                end
            end
            default: begin
                // DONE: everything frozen until reset.
            end
        endcase

        log_nxt = (state_nxt != HOLD) &&
                  (cnt_nxt >= cfg_log_begin) && (cnt_nxt < cfg_log_end);
    end

    // Handshake and status outputs decode directly from the state register.
    assign dut_reset    = (state == HOLD);
    assign init_req     = (state == INIT);
    assign step_req     = (state == RUN);
    assign finish       = (state == DONE);
    assign finish_cause = cause_q;

endmodule : sim_run_ctrl
`default_nettype wire
